sm_seq_shifter: RTL and testbench

//  Multi-cycle, parametrised sign-magnitude barrel-replacement shifter for the ALU datapath.

---
 rtl/sm_alu_pkg.sv | 28 ++
 rtl/sm_seq_shifter.sv | 167 ++++++++++++++++
 tb/tb_sm_seq_shifter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sm_alu_pkg.sv
// Shared types and sign-magnitude helpers for the sequential ALU shifter.
// Helpers operate on a zero-extended wide vector so any operand width up to SM_MAX_W can use them.
package sm_alu_pkg;

    localparam int SM_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sm_shift_state_t;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } sm_shift_dir_t;

    // Sign bit of a w-bit sign-magnitude value held in the low bits of v.
    function automatic logic sm_sign(input logic [SM_MAX_W-1:0] v, input int w);
        return |(v & (SM_MAX_W'(1) << (w - 1)));
    endfunction

    // Magnitude field (bits w-2:0) of a w-bit sign-magnitude value.
    function automatic logic [SM_MAX_W-1:0] sm_mag(input logic [SM_MAX_W-1:0] v, input int w);
        return v & ((SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1));
    endfunction

endpackage

// File: rtl/sm_seq_shifter.sv
// Sequential sign-magnitude shifter: shifts |A| by |B| one bit per clock with a start/done handshake.
// Build option: define SM_SHIFT_SAT_EN to saturate the magnitude on left-shift overflow instead of wrapping.
module sm_seq_shifter
    import sm_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_dir,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_out,
    output logic         o_ERR,
    output logic         o_ovf
);

    localparam int MAG_W = N - 1;
    localparam int CNT_W = $clog2(N);

    sm_shift_state_t r_state;
    sm_shift_state_t w_next_state;

    logic             r_sign;
    logic [MAG_W-1:0] r_mag;
    sm_shift_dir_t    r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_acc;

    logic [N-1:0]     r_out;
    logic             r_err;
    logic             r_ovf;

    logic             w_a_sign;
    logic [MAG_W-1:0] w_a_mag;
    logic             w_b_sign;
    logic [MAG_W-1:0] w_b_mag;
    logic [CNT_W-1:0] w_cnt_init;
    logic [MAG_W-1:0] w_mag_step;
    logic             w_ovf_step;
    logic [MAG_W-1:0] w_mag_final;
    logic             w_accept;
    logic             w_last_step;

`ifdef SM_SHIFT_SAT_EN
    function automatic logic [MAG_W-1:0] sat_mag(input logic [MAG_W-1:0] m, input logic ovf);
        return ovf ? {MAG_W{1'b1}} : m;
    endfunction
`endif

    // Operand slicing and shift-count clamp
    assign w_a_sign = sm_sign(SM_MAX_W'(i_a), N);
    assign w_a_mag  = MAG_W'(sm_mag(SM_MAX_W'(i_a), N));
    assign w_b_sign = sm_sign(SM_MAX_W'(i_b), N);
    assign w_b_mag  = MAG_W'(sm_mag(SM_MAX_W'(i_b), N));

    always_comb begin
        w_cnt_init = CNT_W'(w_b_mag);
        if (w_b_mag >= MAG_W'(N - 1)) begin
            w_cnt_init = CNT_W'(N - 1);
        end
    end

    // One-bit step of the magnitude register
    always_comb begin
        w_mag_step = r_mag;
        w_ovf_step = r_ovf_acc;
        if (r_dir == SH_LEFT) begin
            w_mag_step = {r_mag[MAG_W-2:0], 1'b0};
            w_ovf_step = r_ovf_acc | r_mag[MAG_W-1];
        end else begin
            w_mag_step = {1'b0, r_mag[MAG_W-1:1]};
        end
    end

`ifdef SM_SHIFT_SAT_EN
    assign w_mag_final = sat_mag(w_mag_step, w_ovf_step);
`else
    assign w_mag_final = w_mag_step;
`endif

    assign w_accept    = (r_state == IDLE) && i_start;
    assign w_last_step = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (w_b_sign || (w_cnt_init == '0)) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Working registers: operand latch and per-cycle shift
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_dir     <= SH_LEFT;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
        end else if (w_accept) begin
            r_sign    <= w_a_sign;
            r_mag     <= w_a_mag;
            r_dir     <= sm_shift_dir_t'(i_dir);
            r_cnt     <= w_cnt_init;
            r_ovf_acc <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_mag     <= w_mag_step;
            r_ovf_acc <= w_ovf_step;
            r_cnt     <= r_cnt - CNT_W'(1);
        end
    end

    // Result registers load only on entry to DONE and hold otherwise
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_out <= '0;
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept && w_b_sign) begin
            r_out <= '0;
            r_err <= 1'b1;
            r_ovf <= 1'b0;
        end else if (w_accept && (w_cnt_init == '0)) begin
            r_out <= i_a;
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_last_step) begin
            r_out <= {r_sign, w_mag_final};
            r_err <= 1'b0;
            r_ovf <= w_ovf_step;
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);
    assign o_out  = r_out;
    assign o_ERR  = r_err;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_sm_seq_shifter.sv
// Self-checking bench for sm_seq_shifter (N=8): directed cases, reset/busy corners, then random operations.
// Honours SM_SHIFT_SAT_EN the same way as the design build.
module tb_sm_seq_shifter;

    localparam int N = 8;
    localparam int MAG_W = N - 1;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic         i_dir;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_out;
    logic         o_ERR;
    logic         o_ovf;

    int vectors;
    int miscompares;

    sm_seq_shifter #(.N(N)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_dir   (i_dir),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_out   (o_out),
        .o_ERR   (o_ERR),
        .o_ovf   (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definition of the operation.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic dir,
                         output logic [N-1:0] out, output logic err, output logic ovf,
                         output int lat);
        int cnt;
        int mag;
        int full;
        int limit;
        logic [31:0] m;
        limit = 1 << MAG_W;
        mag   = int'(a) % limit;
        cnt   = int'(b) % limit;
        if (cnt > N - 1) cnt = N - 1;
        err = 1'b0;
        ovf = 1'b0;
        lat = cnt;
        if (b[N-1]) begin
            err = 1'b1;
            out = '0;
            lat = 0;
        end else if (cnt == 0) begin
            out = a;
        end else begin
            if (dir == 1'b0) begin
                full = mag << cnt;
                ovf  = (full >= limit);
                m    = 32'(full % limit);
`ifdef SM_SHIFT_SAT_EN
                if (ovf) m = 32'(limit - 1);
`endif
            end else begin
                m = 32'(mag >> cnt);
            end
            out = {a[N-1], m[MAG_W-1:0]};
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic dir,
                          input string tag);
        logic [N-1:0] e_out;
        logic         e_err;
        logic         e_ovf;
        int           lat;
        int           k;
        model(a, b, dir, e_out, e_err, e_ovf, lat);
        @(negedge i_clk);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        i_dir   = dir;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        k = 0;
        while (o_done !== 1'b1 && k < 20) begin
            chk({tag, "_busy_mid"}, int'(o_busy), 1);
            @(posedge i_clk);
            #1;
            k++;
        end
        chk({tag, "_latency"}, k, lat);
        chk({tag, "_out"}, int'(o_out), int'(e_out));
        chk({tag, "_err"}, int'(o_ERR), int'(e_err));
        chk({tag, "_ovf"}, int'(o_ovf), int'(e_ovf));
        chk({tag, "_busy_done"}, int'(o_busy), 1);
        @(posedge i_clk);
        #1;
        chk({tag, "_done_pulse"}, int'(o_done), 0);
        chk({tag, "_idle"}, int'(o_busy), 0);
        chk({tag, "_hold"}, int'(o_out), int'(e_out));
    endtask

    initial begin
        int k;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rd;
        vectors     = 0;
        miscompares = 0;
        i_rst   = 1'b0;
        i_start = 1'b0;
        i_dir   = 1'b0;
        i_a     = '0;
        i_b     = '0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_out", int'(o_out), 0);
        chk("rst_err", int'(o_ERR), 0);
        chk("rst_ovf", int'(o_ovf), 0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // Directed cases
        run_op(8'h03, 8'h02, 1'b0, "t1_left");
        run_op(8'h85, 8'h05, 1'b0, "t2_left_ovf");
        run_op(8'h9B, 8'h03, 1'b1, "t3_right");
        run_op(8'h40, 8'h7F, 1'b0, "t3_clamp");
        run_op(8'h80, 8'h03, 1'b0, "neg_zero");
        run_op(8'h7F, 8'h81, 1'b1, "t4_err");
        run_op(8'hC5, 8'h00, 1'b0, "t4_cnt0");

        // Async reset in the middle of a shift
        @(negedge i_clk);
        i_start = 1'b1;
        i_a = 8'h7F;
        i_b = 8'h07;
        i_dir = 1'b0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (2) @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        chk("arst_out", int'(o_out), 0);
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_done", int'(o_done), 0);
        chk("arst_err", int'(o_ERR), 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        run_op(8'h01, 8'h03, 1'b0, "after_rst");

        // Start pulsed while busy must be ignored
        @(negedge i_clk);
        i_start = 1'b1;
        i_a = 8'h03;
        i_b = 8'h05;
        i_dir = 1'b0;
        @(posedge i_clk);
        #1;
        i_a = 8'h81;
        i_b = 8'h01;
        i_dir = 1'b1;
        k = 0;
        repeat (3) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        i_start = 1'b0;
        while (o_done !== 1'b1 && k < 20) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        chk("busy_ign_latency", k, 5);
        chk("busy_ign_out", int'(o_out), 8'h60);
        chk("busy_ign_ovf", int'(o_ovf), 0);
        repeat (2) begin
            @(posedge i_clk);
            #1;
            chk("busy_ign_noqueue", int'(o_busy), 0);
        end

        // Back-to-back operations
        run_op(8'h0F, 8'h01, 1'b1, "b2b_a");
        run_op(8'h8F, 8'h02, 1'b0, "b2b_b");

        // Random operations
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) rb[N-1] = 1'b1;
            rd = 1'($urandom);
            run_op(ra, rb, rd, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
